// File: rtl/cpu_wb_stage.sv
// Writeback stage: latches the retiring instruction, drives the register-file write port, counts retirements.
// Optional macro WB_BYPASS_EN adds a same-cycle bypass-hit indication for the decode read ports.
module cpu_wb_stage #(
    parameter int DW   = 16,
    parameter int AW   = 2,
    parameter int PCW  = 10,
    parameter int IMMW = 6,
    parameter int CNTW = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            in_valid,
    input  logic            in_rf_w,
    input  logic [AW-1:0]   in_dest,
    input  logic [1:0]      in_result_sel,
    input  logic [DW-1:0]   in_alu_res,
    input  logic [DW-1:0]   in_mem_rd,
    input  logic [PCW-1:0]  in_pc,
    input  logic [IMMW-1:0] in_imm,
    output logic            rf_w,
    output logic [DW-1:0]   rf_wd,
    output logic [AW-1:0]   dest,
    output logic [CNTW-1:0] retired,
    input  logic [AW-1:0]   rn1,
    input  logic [AW-1:0]   rn2,
    output logic            byp1_hit,
    output logic            byp2_hit
);

    typedef struct packed {
        logic          valid;
        logic          rf_w;
        logic [AW-1:0] dest;
        logic [DW-1:0] data;
    } wb_latch_t;

    wb_latch_t        wb;
    logic [DW-1:0]    sel_data;
    logic [PCW-1:0]   link_pc;

    // Link address wraps within the PC width before zero-extension.
    assign link_pc = in_pc + PCW'(1);

    always_comb begin
        sel_data = '0;
        case (in_result_sel)
            2'd0:    sel_data = in_alu_res;
            2'd1:    sel_data = in_mem_rd;
            2'd2:    sel_data = DW'(link_pc);
            default: sel_data = DW'(in_imm);
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wb      <= '0;
            retired <= '0;
        end else if (flush) begin
            wb.valid <= 1'b0;
            wb.rf_w  <= 1'b0;
        end else if (!stall) begin
            wb.valid <= in_valid;
            wb.rf_w  <= in_valid & in_rf_w;
            wb.dest  <= in_dest;
            wb.data  <= sel_data;
            if (in_valid)
                retired <= retired + CNTW'(1);
        end
    end

    // A stalled latch keeps rewriting the same value; that is intentional.
    assign rf_w  = wb.valid & wb.rf_w;
    assign rf_wd = wb.data;
    assign dest  = wb.dest;

`ifdef WB_BYPASS_EN
    assign byp1_hit = rf_w & (rn1 == wb.dest);
    assign byp2_hit = rf_w & (rn2 == wb.dest);
`else
    logic unused_rn;
    assign unused_rn = ^{rn1, rn2};
    assign byp1_hit  = 1'b0;
    assign byp2_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_wb_stage.sv
// Directed bench for cpu_wb_stage: select paths, stall/flush, reset, counter wrap, bypass hits.
module tb_cpu_wb_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush, in_valid, in_rf_w;
    logic [1:0]  in_dest, in_result_sel, rn1, rn2;
    logic [15:0] in_alu_res, in_mem_rd;
    logic [9:0]  in_pc;
    logic [5:0]  in_imm;
    logic        rf_w, byp1_hit, byp2_hit;
    logic [15:0] rf_wd, retired;
    logic [1:0]  dest;

    int checks   = 0;
    int failures = 0;

`ifdef WB_BYPASS_EN
    localparam logic BYP_ON = 1'b1;
`else
    localparam logic BYP_ON = 1'b0;
`endif

    cpu_wb_stage dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_rf_w(in_rf_w), .in_dest(in_dest),
        .in_result_sel(in_result_sel), .in_alu_res(in_alu_res),
        .in_mem_rd(in_mem_rd), .in_pc(in_pc), .in_imm(in_imm),
        .rf_w(rf_w), .rf_wd(rf_wd), .dest(dest), .retired(retired),
        .rn1(rn1), .rn2(rn2), .byp1_hit(byp1_hit), .byp2_hit(byp2_hit)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic ew, input logic [1:0] ed,
                          input logic [15:0] edata, input logic [15:0] eret);
        chk({tag, ".rf_w"}, 32'(rf_w), 32'(ew));
        chk({tag, ".dest"}, 32'(dest), 32'(ed));
        chk({tag, ".rf_wd"}, 32'(rf_wd), 32'(edata));
        chk({tag, ".retired"}, 32'(retired), 32'(eret));
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; in_valid = 0; in_rf_w = 0;
        in_dest = 0; in_result_sel = 0; in_alu_res = 0; in_mem_rd = 0;
        in_pc = 0; in_imm = 0; rn1 = 0; rn2 = 0;
        tick; tick;
        chk_wb("reset", 1'b0, 2'd0, 16'h0000, 16'd0);
        chk("reset.byp1", 32'(byp1_hit), 32'd0);
        chk("reset.byp2", 32'(byp2_hit), 32'd0);

        reset = 0;
        in_valid = 1; in_rf_w = 1; in_dest = 2; in_result_sel = 0; in_alu_res = 16'h1234;
        tick;
        chk_wb("alu", 1'b1, 2'd2, 16'h1234, 16'd1);

        in_result_sel = 2; in_pc = 10'h3FF;
        tick;
        chk_wb("link_wrap", 1'b1, 2'd2, 16'h0000, 16'd2);

        in_result_sel = 2; in_pc = 10'h0FF;
        tick;
        chk_wb("link", 1'b1, 2'd2, 16'h0100, 16'd3);

        in_result_sel = 3; in_imm = 6'h2A;
        tick;
        chk_wb("imm", 1'b1, 2'd2, 16'h002A, 16'd4);

        in_result_sel = 1; in_mem_rd = 16'hBEEF;
        tick;
        chk_wb("mem", 1'b1, 2'd2, 16'hBEEF, 16'd5);

        in_result_sel = 0; in_dest = 1; in_alu_res = 16'h00AA;
        tick;
        chk_wb("preload", 1'b1, 2'd1, 16'h00AA, 16'd6);

        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_dest = 2'(i + 2); in_alu_res = 16'h5555 + 16'(i);
            tick;
            chk_wb("stall", 1'b1, 2'd1, 16'h00AA, 16'd6);
        end

        flush = 1;
        tick;
        chk("flush.rf_w", 32'(rf_w), 32'd0);
        chk("flush.retired", 32'(retired), 32'd6);

        stall = 0; flush = 0; in_valid = 0; in_rf_w = 1; in_dest = 3;
        tick;
        chk("invalid.rf_w", 32'(rf_w), 32'd0);
        chk("invalid.retired", 32'(retired), 32'd6);

        in_valid = 1; in_dest = 3; in_alu_res = 16'h7777;
        rn1 = 3; rn2 = 0;
        tick;
        chk_wb("byp_load", 1'b1, 2'd3, 16'h7777, 16'd7);
        chk("byp1_hit", 32'(byp1_hit), 32'(BYP_ON));
        chk("byp2_miss", 32'(byp2_hit), 32'd0);
        rn2 = 3; #1;
        chk("byp2_hit", 32'(byp2_hit), 32'(BYP_ON));

        // A valid load with rf_w clear counts but never hits the bypass.
        in_rf_w = 0;
        tick;
        chk("norfw.rf_w", 32'(rf_w), 32'd0);
        chk("norfw.retired", 32'(retired), 32'd8);
        chk("norfw.byp1", 32'(byp1_hit), 32'd0);

        in_rf_w = 1;
        tick;
        chk("pre_rst.rf_w", 32'(rf_w), 32'd1);
        reset = 1; stall = 1;
        tick;
        chk_wb("mid_reset", 1'b0, 2'd0, 16'h0000, 16'd0);

        reset = 0; stall = 0; in_valid = 1; in_rf_w = 1;
        for (int i = 0; i < 65535; i++) tick;
        chk("wrap.pre", 32'(retired), 32'hFFFF);
        tick;
        chk("wrap.post", 32'(retired), 32'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
